adc_serial_port_controller: RTL

Parametrised 3-wire serial register-port master for AFE/ADC configuration ports (AD9826-class). It sits between the sensor-control register logic and the ADC's SCLK/SLOAD/SDATA pins. It accepts write and read commands over a valid/ready handshake and generates the bit-level serial frame internally, with no external SPI core. It handles the bidirectional SDATA turnaround and returns read data with a one-cycle valid strobe.

---
 rtl/adc_serial_port_controller.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_serial_port_controller.sv
// 3-wire serial register-port master for AD9826-class AFE/ADC configuration ports.
// Define ADC_SPI_WRITE_VERIFY_EN to follow every write with an automatic read-back compare.
module adc_serial_port_controller #(
  parameter int ADDR_W     = 3,
  parameter int PAD_W      = 3,
  parameter int DATA_W     = 9,
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_rd_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              sload_o,
  output logic              sdata_o,
  output logic              sdata_oe_o,
  input  logic              sdata_i
`ifdef ADC_SPI_WRITE_VERIFY_EN
  ,
  output logic              verify_err_o
`endif
);

  localparam int FRAME_W = 1 + ADDR_W + PAD_W + DATA_W;
  localparam int DSTART  = 1 + ADDR_W + PAD_W;
  localparam int CMAX    = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CMAX + 1);
  localparam int BW      = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] CD_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [BW-1:0]       bit_idx, bit_n;
  logic                hi_ph, hi_n;
  logic [FRAME_W-1:0]  sh, sh_n;
  logic [DATA_W-1:0]   rx, rx_n, rd_data_n;
  logic                rd_q, rd_n;
  logic                ready_n, busy_n, sclk_n, sload_n, sdata_n, oe_n;
  logic                done_n, rd_valid_n, last_frame;
`ifdef ADC_SPI_WRITE_VERIFY_EN
  logic                vfy_q, vfy_n, err_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
`endif

  function automatic logic [FRAME_W-1:0] mk_frame(input logic rd, input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] d);
    mk_frame = '0;
    mk_frame[FRAME_W-1] = rd;
    mk_frame[FRAME_W-2 -: ADDR_W] = a;
    mk_frame[DATA_W-1:0] = d;
  endfunction

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    hi_n       = hi_ph;
    sh_n       = sh;
    rx_n       = rx;
    rd_n       = rd_q;
    sdata_n    = sdata_o;
    last_frame = 1'b1;
`ifdef ADC_SPI_WRITE_VERIFY_EN
    vfy_n   = vfy_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
`endif
    case (state)
      IDLE: if (cmd_valid_i && cmd_ready_o) begin
        state_n = SETUP;
        cnt_n   = '0;
        rd_n    = cmd_rd_i;
        sh_n    = mk_frame(cmd_rd_i, cmd_addr_i, cmd_rd_i ? '0 : cmd_wdata_i);
`ifdef ADC_SPI_WRITE_VERIFY_EN
        addr_n  = cmd_addr_i;
        wdata_n = cmd_wdata_i;
        vfy_n   = 1'b0;
`endif
      end
      SETUP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CD_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
          hi_n    = 1'b0;
          bit_n   = '0;
          sdata_n = sh[FRAME_W-1];
          sh_n    = sh << 1;
        end
      end
      SHIFT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CD_LAST) begin
          cnt_n = '0;
          if (!hi_ph) begin
            hi_n = 1'b1;
            rx_n = DATA_W'({rx, sdata_i});
          end else if (bit_idx == BW'(FRAME_W - 1)) begin
            state_n = HOLD;
          end else begin
            hi_n    = 1'b0;
            bit_n   = bit_idx + 1'b1;
            sdata_n = sh[FRAME_W-1];
            sh_n    = sh << 1;
          end
        end
      end
      HOLD: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CD_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      GAP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
`ifdef ADC_SPI_WRITE_VERIFY_EN
          if (!rd_q) begin
            state_n = SETUP;
            rd_n    = 1'b1;
            vfy_n   = 1'b1;
            sh_n    = mk_frame(1'b1, addr_q, '0);
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef ADC_SPI_WRITE_VERIFY_EN
    last_frame = rd_q;
`endif
    // done coincides with the final GAP cycle, so ready can return on the next one
    done_n     = (state_n == GAP) && (cnt_n == GAP_LAST) && last_frame;
    rd_valid_n = done_n && rd_q;
`ifdef ADC_SPI_WRITE_VERIFY_EN
    rd_valid_n = rd_valid_n && !vfy_q;
    err_n      = done_n && vfy_q && (rx != wdata_q);
`endif
    rd_data_n  = rd_valid_n ? rx : rd_data_o;
    ready_n    = (state_n == IDLE);
    busy_n     = !ready_n;
    sclk_n     = (state_n == SHIFT) && hi_n;
    sload_n    = !(state_n inside {SETUP, SHIFT, HOLD});
    oe_n       = !((state_n inside {SHIFT, HOLD}) && rd_n && (bit_n >= BW'(DSTART)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      hi_ph       <= 1'b0;
      sh          <= '0;
      rx          <= '0;
      rd_q        <= 1'b0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      sclk_o      <= 1'b0;
      sload_o     <= 1'b1;
      sdata_o     <= 1'b0;
      sdata_oe_o  <= 1'b1;
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      done_o      <= 1'b0;
`ifdef ADC_SPI_WRITE_VERIFY_EN
      vfy_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      verify_err_o <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      hi_ph       <= hi_n;
      sh          <= sh_n;
      rx          <= rx_n;
      rd_q        <= rd_n;
      cmd_ready_o <= ready_n;
      busy_o      <= busy_n;
      sclk_o      <= sclk_n;
      sload_o     <= sload_n;
      sdata_o     <= sdata_n;
      sdata_oe_o  <= oe_n;
      rd_data_o   <= rd_data_n;
      rd_valid_o  <= rd_valid_n;
      done_o      <= done_n;
`ifdef ADC_SPI_WRITE_VERIFY_EN
      vfy_q        <= vfy_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      verify_err_o <= err_n;
`endif
    end
  end

endmodule
